// File: rtl/xadc_drp_responder.sv
// -----------------------------------------------------------------------------
// xadc_drp_responder
//
// Behavioural stand-in for the XADC hard macro, for simulation and for builds
// without an XADC. Pin-compatible with the xadc_wiz_0 DRP/EOC ports.
//
// Contents:
//   - 128 x 16 DRP register space.
//     * 0x00-0x3F: read-only status. Only 0x10-0x1F (the VAUX results) are
//       stored; the other status addresses read as 0.
//     * 0x40-0x7F: read/write config.
//     * 0x49: VAUX enable mask for the sequencer.
//   - Conversion sequencer. It visits the enabled VAUX channels round-robin.
//     For each one it latches sample_data into status[0x10+idx] and then
//     pulses eoc_out.
//
// Parameters:
//   READ_LAT     : clocks from the den_in cycle to drdy_out (1..8)
//   CONV_CYCLES  : clocks per conversion, i.e. the busy_out window (>= 2)
//   SEQ_MASK_RST : reset value of the enable mask (reg 0x49)
//
// Ports:
//   CLK100MHZ, rstn         clock, asynchronous active-low reset
//   daddr_in/den_in/dwe_in/di_in   DRP request
//   do_out/drdy_out         DRP response; do_out holds until the next drdy
//   busy_out, eoc_out       conversion window, end-of-conversion pulse
//   channel_out             0x10 + index of the last completed conversion
//   req_ch                  VAUX index currently being converted
//   sample_data             analog stand-in, sampled on the last conversion
//                           clock
//   err_out                 sticky protocol error
//
// Optional feature (macro DRP_ERR_CHECK_EN):
//   err_out sets on den_in while a transaction is in flight, or on a write to
//   status space. With the macro undefined, err_out is tied to 0.
// -----------------------------------------------------------------------------
module xadc_drp_responder #(
    parameter int          READ_LAT     = 2,
    parameter int          CONV_CYCLES  = 26,
    parameter logic [15:0] SEQ_MASK_RST = 16'hC0C0
) (
    input  logic        CLK100MHZ,
    input  logic        rstn,
    input  logic [6:0]  daddr_in,
    input  logic        den_in,
    input  logic        dwe_in,
    input  logic [15:0] di_in,
    output logic [15:0] do_out,
    output logic        drdy_out,
    output logic        busy_out,
    output logic        eoc_out,
    output logic [4:0]  channel_out,
    output logic [3:0]  req_ch,
    input  logic [15:0] sample_data,
    output logic        err_out
);

    localparam int LAT_W = $clog2(READ_LAT + 1);
    localparam int CNT_W = (CONV_CYCLES > 2) ? $clog2(CONV_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_EOC} seq_state_t;

    // First enabled index strictly after cur, wrapping 15->0. If cur is the
    // only enabled bit, the scan comes back around to cur itself.
    function automatic logic [3:0] next_enabled(input logic [3:0] cur,
                                                input logic [15:0] mask);
        logic [3:0] sel;
        logic [3:0] idx;
        logic       found;
        sel   = cur;
        found = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            idx = cur + 4'(i);
            if (!found && mask[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    // ---------------------------------------------------------------- storage
    logic [15:0] stat_q [16];   // status 0x10-0x1F
    logic [15:0] cfg_q  [64];   // config 0x40-0x7F
    logic [15:0] seq_mask;

    assign seq_mask = cfg_q[6'h09];

    // -------------------------------------------------------------------- DRP
    logic [LAT_W-1:0] lat_cnt;
    logic [15:0]      rd_capt;
    logic [15:0]      rd_data;
    logic             in_flight;
    logic             accept;
    logic             cfg_wr;

    assign in_flight = (lat_cnt != '0);
    assign accept    = den_in && !in_flight;
    assign cfg_wr    = accept && dwe_in && daddr_in[6];

    always_comb begin
        rd_data = 16'h0000;
        if (!dwe_in) begin
            if (daddr_in[6])
                rd_data = cfg_q[daddr_in[5:0]];
            else if (daddr_in[5:4] == 2'b01)
                rd_data = stat_q[daddr_in[3:0]];
        end
    end

    // Read data is frozen on the den cycle, so a result written by the
    // sequencer on that same edge is not seen: the read returns the old value.
    always_ff @(posedge CLK100MHZ or negedge rstn) begin
        if (!rstn) begin
            lat_cnt  <= '0;
            rd_capt  <= '0;
            drdy_out <= 1'b0;
            do_out   <= '0;
        end else begin
            drdy_out <= 1'b0;
            if (accept) begin
                if (READ_LAT == 1) begin
                    drdy_out <= 1'b1;
                    do_out   <= rd_data;
                end else begin
                    lat_cnt <= LAT_W'(READ_LAT - 1);
                    rd_capt <= rd_data;
                end
            end else if (in_flight) begin
                lat_cnt <= lat_cnt - LAT_W'(1);
                if (lat_cnt == LAT_W'(1)) begin
                    drdy_out <= 1'b1;
                    do_out   <= rd_capt;
                end
            end
        end
    end

    // -------------------------------------------------------------- sequencer
    seq_state_t       state, state_nxt;
    logic [CNT_W-1:0] conv_cnt;
    logic [3:0]       cur_idx;
    logic [3:0]       sel_idx;
    logic             conv_last;
    logic             load_idx;
    logic             res_wr;

    assign conv_last = (conv_cnt == CNT_W'(CONV_CYCLES - 1));
    assign sel_idx   = next_enabled(cur_idx, seq_mask);
    assign res_wr    = (state == S_CONV) && conv_last;

    always_ff @(posedge CLK100MHZ or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy_out  = 1'b0;
        eoc_out   = 1'b0;
        load_idx  = 1'b0;
        case (state)
            S_IDLE: begin
                if (seq_mask != 16'h0000) begin
                    load_idx  = 1'b1;
                    state_nxt = S_CONV;
                end
            end
            S_CONV: begin
                busy_out = 1'b1;
                if (conv_last) state_nxt = S_EOC;
            end
            S_EOC: begin
                eoc_out = 1'b1;
                if (seq_mask != 16'h0000) begin
                    load_idx  = 1'b1;
                    state_nxt = S_CONV;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // cur_idx and req_ch carry the same value once the first channel has been
    // picked. They are kept separate because the scan must start after index
    // 15, while every output must still read 0 out of reset.
    always_ff @(posedge CLK100MHZ or negedge rstn) begin
        if (!rstn) begin
            conv_cnt    <= '0;
            cur_idx     <= 4'hF;
            req_ch      <= 4'h0;
            channel_out <= 5'h00;
        end else begin
            if (load_idx) begin
                cur_idx  <= sel_idx;
                req_ch   <= sel_idx;
                conv_cnt <= '0;
            end else if ((state == S_CONV) && !conv_last) begin
                conv_cnt <= conv_cnt + CNT_W'(1);
            end
            if (res_wr) channel_out <= {1'b1, req_ch};
        end
    end

    // --------------------------------------------------------- register file
    // The result lands on the edge entering S_EOC, so a read strobed by
    // eoc_out already sees it.
    always_ff @(posedge CLK100MHZ or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 16; i++) stat_q[i] <= 16'h0000;
            for (int i = 0; i < 64; i++) cfg_q[i]  <= (i == 9) ? SEQ_MASK_RST : 16'h0000;
        end else begin
            if (cfg_wr) cfg_q[daddr_in[5:0]] <= di_in;
            if (res_wr) stat_q[req_ch]       <= sample_data;
        end
    end

    // ------------------------------------------------------------- err_out
`ifdef DRP_ERR_CHECK_EN
    always_ff @(posedge CLK100MHZ or negedge rstn) begin
        if (!rstn)
            err_out <= 1'b0;
        else if ((den_in && in_flight) || (accept && dwe_in && !daddr_in[6]))
            err_out <= 1'b1;
    end
`else
    assign err_out = 1'b0;
`endif

endmodule

// File: tb/tb_xadc_drp_responder.sv
// Self-checking bench for xadc_drp_responder.
// The reference model tracks register contents in arrays. It predicts the
// sequencer's channel order from the enable mask, using round-robin
// arithmetic.
module tb_xadc_drp_responder;

    localparam int          READ_LAT    = 2;
    localparam int          CONV_CYCLES = 26;
    localparam logic [15:0] MASK_RST    = 16'hC0C0;

    logic        clk = 1'b0;
    logic        rstn;
    logic [6:0]  daddr;
    logic        den, dwe;
    logic [15:0] di, do_out, sample_data;
    logic        drdy_out, busy_out, eoc_out, err_out;
    logic [4:0]  channel_out;
    logic [3:0]  req_ch;

    xadc_drp_responder #(
        .READ_LAT(READ_LAT), .CONV_CYCLES(CONV_CYCLES), .SEQ_MASK_RST(MASK_RST)
    ) dut (
        .CLK100MHZ(clk), .rstn(rstn), .daddr_in(daddr), .den_in(den),
        .dwe_in(dwe), .di_in(di), .do_out(do_out), .drdy_out(drdy_out),
        .busy_out(busy_out), .eoc_out(eoc_out), .channel_out(channel_out),
        .req_ch(req_ch), .sample_data(sample_data), .err_out(err_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------ model
    int          n_chk = 0, n_err = 0;
    logic [15:0] stat [64];
    logic [15:0] cfg  [64];
    logic [15:0] m_mask;
    int          m_cur, m_last, tprev;

    function automatic int nxt(int cur, logic [15:0] mask);
        for (int k = 1; k <= 16; k++)
            if (mask[(cur + k) % 16]) return (cur + k) % 16;
        return cur;
    endfunction

    function automatic logic [15:0] mread(logic [6:0] a);
        return a[6] ? cfg[a[5:0]] : stat[a[5:0]];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin stat[i] = 16'h0; cfg[i] = 16'h0; end
        cfg[9] = MASK_RST;
        m_mask = MASK_RST;
        m_cur  = nxt(15, MASK_RST);
        m_last = -1;
        tprev  = -1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_eoc(output int seen);
        int n;
        tick(); n = 1;
        while (!eoc_out && n < 200) begin tick(); n++; end
        seen = eoc_out ? 1 : 0;
    endtask

    // Called in the eoc cycle.
    task automatic eoc_model(input string tag);
        chk({tag, "_ch"}, 32'(channel_out), 32'(16 + m_cur));
        chk({tag, "_req"}, 32'(req_ch), 32'(m_cur));
        chk({tag, "_busy"}, 32'(busy_out), 0);
        if (tprev >= 0) chk({tag, "_period"}, 32'(cyc - tprev), 32'(CONV_CYCLES + 1));
        stat[16 + m_cur] = sample_data;
        m_last = m_cur;
        if (m_mask != 16'h0) begin
            m_cur = nxt(m_cur, m_mask);
            tprev = cyc;
        end else begin
            tprev = -1;
        end
    endtask

    task automatic eoc_step(input string tag);
        int seen;
        wait_eoc(seen);
        chk({tag, "_seen"}, 32'(seen), 1);
        if (seen == 1) eoc_model(tag);
    endtask

    task automatic drp(input string tag, input logic [6:0] a, input logic we,
                       input logic [15:0] d);
        logic [15:0] exp;
        int lat;
        exp   = we ? 16'h0 : mread(a);
        daddr = a; dwe = we; di = d; den = 1'b1;
        tick();
        den = 1'b0; dwe = 1'b0;
        lat = 1;
        while (!drdy_out && lat < 12) begin tick(); lat++; end
        chk({tag, "_lat"}, 32'(lat), 32'(READ_LAT));
        chk({tag, "_do"}, 32'(do_out), 32'(exp));
        if (we && a[6]) begin
            cfg[a[5:0]] = d;
            if (a == 7'h49) m_mask = d;
        end
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        int          exp_seq [5];
        int          bad, cnt;
        logic [15:0] old;
        logic [6:0]  a;
        exp_seq = '{6, 7, 14, 15, 6};

        rstn = 1'b0; den = 1'b0; dwe = 1'b0; daddr = '0; di = '0;
        sample_data = 16'h8000;
        model_reset();
        repeat (3) tick();
        chk("rst_busy", 32'(busy_out), 0);
        chk("rst_eoc",  32'(eoc_out), 0);
        chk("rst_drdy", 32'(drdy_out), 0);
        chk("rst_do",   32'(do_out), 0);
        chk("rst_ch",   32'(channel_out), 0);
        chk("rst_req",  32'(req_ch), 0);
        chk("rst_err",  32'(err_out), 0);
        rstn = 1'b1;

        // Read latency and reset value of the mask register
        drp("t2_mask", 7'h49, 1'b0, 16'h0);
        chk("t2_mask_val", 32'(do_out), 32'hC0C0);
        tick();
        chk("t2_drdy_pulse", 32'(drdy_out), 0);
        chk("t2_do_hold", 32'(do_out), 32'hC0C0);
        chk("t2_busy", 32'(busy_out), 1);

        // Channel order under the reset mask
        for (int i = 0; i < 5; i++) begin
            int seen;
            wait_eoc(seen);
            chk("t3_seen", 32'(seen), 1);
            chk("t3_seq", 32'(channel_out), 32'(16 + exp_seq[i]));
            if (seen == 1) eoc_model("t3");
        end
        drp("t3_rd16", 7'h16, 1'b0, 16'h0);

        // eoc-strobed read of the VAUX6 result
        sample_data = 16'h4A30;
        for (int i = 0; i < 4; i++) begin
            eoc_step("t4");
            if (m_last == 6) break;
        end
        daddr = 7'h16; dwe = 1'b0; den = eoc_out;
        tick(); den = 1'b0;
        chk("t4_early", 32'(drdy_out), 0);
        tick();
        chk("t4_drdy", 32'(drdy_out), 1);
        chk("t4_do", 32'(do_out), 32'h4A30);

        // Read strobed on the same edge that writes the result returns the old value
        sample_data = 16'h1234;
        a = 7'(16 + m_cur);
        while (cyc < tprev + CONV_CYCLES) tick();
        old = stat[a[5:0]];
        daddr = a; den = 1'b1;
        tick(); den = 1'b0;
        chk("col_eoc", 32'(eoc_out), 1);
        eoc_model("col");
        tick();
        chk("col_drdy", 32'(drdy_out), 1);
        chk("col_do", 32'(do_out), 32'(old));
        drp("col_new", a, 1'b0, 16'h0);

        // Random samples, config traffic, and dropped status writes
        for (int it = 0; it < 8; it++) begin
            sample_data = 16'($urandom);
            eoc_step("rnd");
            for (int k = 0; k < 3; k++) begin
                case ($urandom_range(0, 2))
                    0: begin
                        a = 7'h40 | 7'($urandom_range(0, 63));
                        if (a == 7'h49) a = 7'h4A;
                        drp("rnd_cfgw", a, 1'b1, 16'($urandom));
                        drp("rnd_cfgr", a, 1'b0, 16'h0);
                    end
                    1: begin
                        a = 7'($urandom_range(0, 63));
                        drp("rnd_stw", a, 1'b1, 16'($urandom));
                        drp("rnd_str", a, 1'b0, 16'h0);
                    end
                    default: drp("rnd_vaux", 7'(16 + $urandom_range(0, 15)), 1'b0, 16'h0);
                endcase
            end
        end

        // Mask change mid-conversion, then disable the sequencer
        eoc_step("t5a");
        repeat (5) tick();
        chk("t5_busy", 32'(busy_out), 1);
        drp("t5_wr1", 7'h49, 1'b1, 16'h0001);
        eoc_step("t5b");
        for (int i = 0; i < 2; i++) begin
            eoc_step("t5c");
            chk("t5_ch10", 32'(channel_out), 32'h10);
        end
        repeat (3) tick();
        drp("t5_wr0", 7'h49, 1'b1, 16'h0000);
        eoc_step("t5d");
        chk("t5_last", 32'(channel_out), 32'h10);
        bad = 0;
        repeat (60) begin tick(); if (busy_out || eoc_out) bad++; end
        chk("t5_idle", 32'(bad), 0);

        // Reset mid-conversion and mid-transaction
        drp("t1_cfgw", 7'h55, 1'b1, 16'hBEEF);
        drp("t1_mask", 7'h49, 1'b1, 16'hFFFF);
        repeat (8) tick();
        chk("t1_busy", 32'(busy_out), 1);
        drp("t1_pre", 7'h49, 1'b0, 16'h0);
        daddr = 7'h55; den = 1'b1;
        tick(); den = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("t1_busy0", 32'(busy_out), 0);
        chk("t1_eoc0",  32'(eoc_out), 0);
        chk("t1_drdy0", 32'(drdy_out), 0);
        chk("t1_do0",   32'(do_out), 0);
        chk("t1_ch0",   32'(channel_out), 0);
        chk("t1_req0",  32'(req_ch), 0);
        chk("t1_err0",  32'(err_out), 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        model_reset();
        cnt = 0;
        repeat (4) begin tick(); if (drdy_out) cnt++; end
        chk("t1_nodrdy", 32'(cnt), 0);
        drp("t1_rmask", 7'h49, 1'b0, 16'h0);
        chk("t1_rmask_val", 32'(do_out), 32'hC0C0);
        drp("t1_rcfg", 7'h55, 1'b0, 16'h0);
        drp("t1_rstat", 7'h17, 1'b0, 16'h0);

        // Status write and double den
        sample_data = 16'($urandom);
        eoc_step("t6");
        drp("t6_wr", 7'h16, 1'b1, 16'hFFFF);
        drp("t6_rd", 7'h16, 1'b0, 16'h0);
`ifdef DRP_ERR_CHECK_EN
        chk("t6_err", 32'(err_out), 1);
`else
        chk("t6_err", 32'(err_out), 0);
`endif
        daddr = 7'h40; dwe = 1'b0; den = 1'b1;
        cnt = 0;
        tick(); if (drdy_out) cnt++;
        tick(); den = 1'b0; if (drdy_out) cnt++;
        repeat (5) begin tick(); if (drdy_out) cnt++; end
        chk("t6_single_drdy", 32'(cnt), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
